// File: rtl/sprite_rom_scheduler_if.sv
// Bus between the sprite renderers / sync generator and the sprite ROM
// scheduler.
//
// Handshake: req is a level-sensitive request from each renderer. It is
// sampled only once per line, on the capture clock. load is the grant. It is
// one-hot and stays high for a whole slot, and it needs no acknowledge. While
// load[i] is high, rom_addr carries the live rom_addr_in slice of renderer i.
// overrun is a single-cycle event flag.
interface sprite_rom_scheduler_if #(
   parameter int NUM_SPRITES = 4,
   parameter int ADDR_W      = 4,
   parameter int HPOS_W      = 10
);
   logic [HPOS_W-1:0]             hpos;
   logic [NUM_SPRITES-1:0]        req;
   logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_in;
   logic [NUM_SPRITES-1:0]        load;
   logic [ADDR_W-1:0]             rom_addr;
   logic                          busy;
   logic                          overrun;

   // renderers and sync generator side
   modport master (
      output hpos, req, rom_addr_in,
      input  load, rom_addr, busy, overrun
   );

   // scheduler side
   modport slave (
      input  hpos, req, rom_addr_in,
      output load, rom_addr, busy, overrun
   );
endinterface

// File: rtl/sprite_rom_scheduler.sv
// Shares the single car sprite ROM between NUM_SPRITES renderers during
// horizontal blanking. Requests are snapshotted at hpos == HBLANK_START. Each
// captured renderer then receives an exclusive SLOT_CYCLES-clock slot, and the
// slots run back to back.
// Build option: define SPRITE_SCHED_RR_EN for round-robin arbitration with a
// pointer that persists across lines. Without it, the lowest index wins.
module sprite_rom_scheduler #(
   parameter int NUM_SPRITES  = 4,
   parameter int ADDR_W       = 4,
   parameter int HPOS_W       = 10,
   parameter int HBLANK_START = 640,
   parameter int HTOTAL       = 800,
   parameter int SLOT_CYCLES  = 4
) (
   input  logic                         clk,
   input  logic                         reset,       // async, active low
   sprite_rom_scheduler_if.slave        bus,
   output logic [1:0]                   o_dbg_state
);
   localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                 r_state;
   logic [NUM_SPRITES-1:0] r_pending;
   logic [NUM_SPRITES-1:0] r_load;
   logic [SEL_W-1:0]       r_sel;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_overrun;

   logic [SEL_W-1:0]       w_ptr;
   logic [NUM_SPRITES-1:0] w_sel_mask;
   logic [NUM_SPRITES-1:0] w_rest;
   logic [NUM_SPRITES-1:0] w_cand;
   logic [NUM_SPRITES-1:0] w_onehot;
   logic [SEL_W-1:0]       w_pick;
   logic                   w_found;
   logic                   w_fits;
   logic                   w_last;
   logic                   w_capture;
   logic                   w_wrap;
   int                     w_idx;

`ifdef SPRITE_SCHED_RR_EN
   logic [SEL_W-1:0]       r_ptr;
   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   assign w_capture  = (bus.hpos == HPOS_W'(HBLANK_START));
   assign w_wrap     = (bus.hpos == '0);
   assign w_last     = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
   // A slot started now occupies hpos+1 .. hpos+SLOT_CYCLES, all inside the line.
   assign w_fits     = ((int'(bus.hpos) + 1 + SLOT_CYCLES) <= HTOTAL);
   assign w_sel_mask = NUM_SPRITES'(1) << r_sel;
   assign w_rest     = r_pending & ~w_sel_mask;
   // At capture the candidates are the live requests, and otherwise they are
   // what remains after the current slot.
   assign w_cand     = (r_state == S_IDLE) ? bus.req : w_rest;
   assign w_onehot   = NUM_SPRITES'(1) << w_pick;

   // Arbiter: first set candidate, searching upward from the pointer with wrap
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
         w_idx = int'(w_ptr) + k;
         if (w_idx >= NUM_SPRITES) w_idx = w_idx - NUM_SPRITES;
         if (!w_found && w_cand[SEL_W'(w_idx)]) begin
            w_found = 1'b1;
            w_pick  = SEL_W'(w_idx);
         end
      end
   end

   // Scheduler FSM: capture, back-to-back slots, end-of-line wait
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_load    <= '0;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_overrun <= 1'b0;
`ifdef SPRITE_SCHED_RR_EN
         r_ptr     <= '0;
`endif
      end else begin
         r_overrun <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_capture) begin
                  r_cnt <= '0;
                  if (!w_found) begin
                     r_pending <= '0;
                     r_state   <= S_DONE;
                  end else if (!w_fits) begin
                     r_overrun <= 1'b1;
                     r_pending <= '0;
                     r_state   <= S_DONE;
                  end else begin
                     r_pending <= bus.req;
                     r_sel     <= w_pick;
                     r_load    <= w_onehot;
                     r_state   <= S_GRANT;
`ifdef SPRITE_SCHED_RR_EN
                     r_ptr     <= (w_pick == SEL_W'(NUM_SPRITES - 1)) ? '0 : w_pick + 1'b1;
`endif
                  end
               end
            end
            S_GRANT: begin
               if (w_wrap) begin
                  // The line ended under us. Abandon the slot and drop the rest.
                  r_load    <= '0;
                  r_overrun <= |w_rest;
                  r_pending <= '0;
                  r_cnt     <= '0;
                  r_state   <= S_IDLE;
               end else if (w_last) begin
                  r_cnt <= '0;
                  if (!w_found) begin
                     r_pending <= '0;
                     r_load    <= '0;
                     r_state   <= S_DONE;
                  end else if (!w_fits) begin
                     r_overrun <= 1'b1;
                     r_pending <= '0;
                     r_load    <= '0;
                     r_state   <= S_DONE;
                  end else begin
                     r_pending <= w_rest;
                     r_sel     <= w_pick;
                     r_load    <= w_onehot;
`ifdef SPRITE_SCHED_RR_EN
                     r_ptr     <= (w_pick == SEL_W'(NUM_SPRITES - 1)) ? '0 : w_pick + 1'b1;
`endif
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (w_wrap) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.load     = r_load;
   assign bus.busy     = |r_load;
   assign bus.overrun  = r_overrun;
   assign bus.rom_addr = (|r_load) ? bus.rom_addr_in[r_sel*ADDR_W +: ADDR_W] : '0;
   assign o_dbg_state  = r_state;
endmodule

// File: doc/sprite_rom_scheduler.md
# sprite_rom_scheduler

Time-multiplexes the single car sprite bitmap ROM between up to NUM_SPRITES sprite renderers during horizontal blanking. Each line, at a fixed hpos, it snapshots the requesting renderers and grants each, in arbitrated order, an exclusive slot of SLOT_CYCLES clocks. During a slot it drives that renderer's load strobe and steers its row address onto the ROM. It replaces fixed hpos windows for load in the racing game top level and scales to more enemy cars.

## Interface
- NUM_SPRITES, 4, number of requesting renderers (2..8)
- ADDR_W, 4, ROM row address width (sprite yofs)
- HPOS_W, 10, width of hpos
- HBLANK_START, 640, hpos value at which requests are captured
- HTOTAL, 800, clocks per line; hpos runs 0..HTOTAL-1
- SLOT_CYCLES, 4, clocks per grant (≥2)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  HPOS_W  current horizontal position from the sync generator
- req  in  NUM_SPRITES  renderer i needs a ROM row this line
- rom_addr_in  in  NUM_SPRITES*ADDR_W  flattened row addresses; slice i belongs to renderer i
- load  out  NUM_SPRITES  one-hot load strobe to renderer i, high for its whole slot
- rom_addr  out  ADDR_W  address to the ROM; the granted slice, else 0
- busy  out  1  high while any slot is active
- overrun  out  1  one-cycle pulse when a captured request is dropped for lack of time

## Operation
- States: IDLE, GRANT, DONE.
- IDLE: when hpos == HBLANK_START, capture pending <= req. If pending is nonzero, go to GRANT. If it is zero, go to DONE.
- Arbitration picks one pending index. The pick is made in the capture cycle and in the last cycle of each slot, so back-to-back slots have no gap.
- GRANT: load[sel] = 1 and rom_addr = rom_addr_in[sel] for exactly SLOT_CYCLES clocks. Clear pending[sel] at the end of the slot.
- At the end of a slot:
  - If pending is empty, go to DONE.
  - If a new slot cannot finish before the line ends (hpos+1+SLOT_CYCLES > HTOTAL), pulse overrun, discard pending and go to DONE.
  - Otherwise start the next slot.
- The same budget check applies at capture: if the first slot does not fit, pulse overrun and go to DONE with no grants.
- DONE: wait for hpos == 0, then go to IDLE.
- Changes to req after capture are ignored until the next line. rom_addr_in is sampled live during a slot.
- If hpos wraps to 0 while in GRANT (abnormal), abort the slot, pulse overrun if any bit is still pending, and go to IDLE.
- Reset: state IDLE, pending 0, round-robin pointer 0. load, rom_addr, busy and overrun all 0.

## Timing
- Capture edge: the clock where hpos == HBLANK_START. load for the first grant rises at the next clock.
- Each slot is exactly SLOT_CYCLES clocks. With n grants, load bits are high for n*SLOT_CYCLES consecutive clocks.
- rom_addr is combinational from the registered sel and the live rom_addr_in, so it is valid in the same cycle as load.
- busy equals |load.
- Reset deassertion takes effect on the first clk edge after release. No grant is issued before the next HBLANK_START capture.

## Configuration
- SPRITE_SCHED_RR_EN defined: round-robin arbitration. The search starts at the index after the last granted one, wraps modulo NUM_SPRITES, and the pointer persists across lines. This way starved renderers win first on the following line.
- Not defined: fixed priority, lowest index first, every line. The pointer logic is absent.

## Test plan
- Defaults, req=4'b0101 at hpos 640 → load[0] high for hpos 641–644, then load[2] for 645–648. rom_addr follows slices 0 and 2; busy stays low after 648.
- req=0 at capture → no load bits, busy low, no overrun; returns to IDLE at hpos 0.
- HBLANK_START=788, HTOTAL=800, req=4'b1111, fixed priority → grants to 0 and 1 only, then an overrun pulse at the cycle the second slot ends. With SPRITE_SCHED_RR_EN, the next line serves 2 and 3 first.
- req dropped to 0 at hpos 642 while slot 0 is active → slot 0 completes through 644 and the other captured grants proceed unchanged.
- reset driven low at hpos 643 mid-slot → load, rom_addr, busy drop to 0 asynchronously. After release, no load until the next hpos 640.
- hpos forced 0 during GRANT with two bits still pending → slot aborted, one overrun pulse, IDLE, and normal capture on the following line.
